// File: rtl/store_buffer_pkg.sv
// Shared LC-3b out-of-order types used by the store buffer: word, ROB tag, CDB broadcast, write FSM state.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_rob_addr;

  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     data;
  } cdb_t;

  typedef enum logic {IDLE, WRITE} sb_state_t;
endpackage

// File: rtl/store_buffer_if.sv
// Dcache write port between the store buffer (master) and the data cache (slave).
interface store_buffer_if #(parameter int data_width = 16);
  logic [data_width-1:0] dmem_addr;
  logic [data_width-1:0] dmem_wdata;
  logic                  dmem_write;
  logic [1:0]            dmem_wmask;
  logic                  dmem_resp;

  modport master(output dmem_addr, dmem_wdata, dmem_write, dmem_wmask, input dmem_resp);
  modport slave (input dmem_addr, dmem_wdata, dmem_write, dmem_wmask, output dmem_resp);
endinterface

// File: rtl/store_buffer_data.sv
// Store buffer entry array: operands, producer tags, ready/committed bits and CDB capture.
// STORE_BUFFER_STB_EN adds a per-entry byte-store flag.
module store_buffer_data
  import lc3b_types::*;
#(
  parameter int data_width   = 16,
  parameter int entries_addr = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc,
  input  logic [entries_addr-1:0] tail,
  input  logic [entries_addr-1:0] head,
  input  logic                    pop,
  input  logic                    flush,
  input  logic                    commit,
  input  lc3b_rob_addr            commit_tag,
  input  cdb_t                    cdb,
  input  logic [data_width-1:0]   base_V,
  input  logic                    base_valid,
  input  lc3b_rob_addr            base_Q,
  input  logic [data_width-1:0]   src_V,
  input  logic                    src_valid,
  input  lc3b_rob_addr            src_Q,
  input  logic [data_width-1:0]   offset_in,
  input  lc3b_rob_addr            dest_in,
`ifdef STORE_BUFFER_STB_EN
  input  logic                    byte_in,
  output logic                    head_byte,
`endif
  output logic                    head_valid,
  output logic                    head_ready,
  output logic                    head_committed,
  output logic                    head_commit_hit,
  output logic [data_width-1:0]   head_base,
  output logic [data_width-1:0]   head_src,
  output logic [data_width-1:0]   head_offset,
  output lc3b_rob_addr            head_dest,
  output logic [entries_addr:0]   keep_cnt
);
  localparam int N = 1 << entries_addr;

  logic [N-1:0]          valid, base_rdy, src_rdy, committed, commit_hit;
  logic [data_width-1:0] base_v [N];
  logic [data_width-1:0] src_v  [N];
  logic [data_width-1:0] offset [N];
  lc3b_rob_addr          base_q [N];
  lc3b_rob_addr          src_q  [N];
  lc3b_rob_addr          dest   [N];
`ifdef STORE_BUFFER_STB_EN
  logic [N-1:0]          is_byte;
  assign head_byte = is_byte[head];
`endif

  logic alloc_base_hit, alloc_src_hit;
  assign alloc_base_hit = !base_valid && cdb.valid && (cdb.tag == base_Q);
  assign alloc_src_hit  = !src_valid  && cdb.valid && (cdb.tag == src_Q);

  // keep_cnt counts entries that survive a flush, including ones committing this cycle
  always_comb begin
    commit_hit = '0;
    keep_cnt   = '0;
    for (int i = 0; i < N; i++) begin
      commit_hit[i] = commit && valid[i] && !committed[i] && (dest[i] == commit_tag);
      keep_cnt      = keep_cnt + {{entries_addr{1'b0}}, valid[i] & (committed[i] | commit_hit[i])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      base_rdy  <= '0;
      src_rdy   <= '0;
      committed <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc && tail == entries_addr'(i)) begin
          valid[i]     <= 1'b1;
          committed[i] <= 1'b0;
          base_rdy[i]  <= base_valid | alloc_base_hit;
          src_rdy[i]   <= src_valid  | alloc_src_hit;
          base_v[i]    <= alloc_base_hit ? cdb.data : base_V;
          src_v[i]     <= alloc_src_hit  ? cdb.data : src_V;
          base_q[i]    <= base_Q;
          src_q[i]     <= src_Q;
          offset[i]    <= offset_in;
          dest[i]      <= dest_in;
`ifdef STORE_BUFFER_STB_EN
          is_byte[i]   <= byte_in;
`endif
        end else if (valid[i]) begin
          if (pop && head == entries_addr'(i)) begin
            valid[i]     <= 1'b0;
            committed[i] <= 1'b0;
          end else begin
            if (!base_rdy[i] && cdb.valid && cdb.tag == base_q[i]) begin
              base_v[i]   <= cdb.data;
              base_rdy[i] <= 1'b1;
            end
            if (!src_rdy[i] && cdb.valid && cdb.tag == src_q[i]) begin
              src_v[i]   <= cdb.data;
              src_rdy[i] <= 1'b1;
            end
            if (commit_hit[i]) committed[i] <= 1'b1;
            if (flush && !(committed[i] | commit_hit[i])) valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign head_valid      = valid[head];
  assign head_ready      = base_rdy[head] & src_rdy[head];
  assign head_committed  = committed[head];
  assign head_commit_hit = commit_hit[head];
  assign head_base       = base_v[head];
  assign head_src        = src_v[head];
  assign head_offset     = offset[head];
  assign head_dest       = dest[head];
endmodule

// File: rtl/store_buffer.sv
// Store buffer top: circular FIFO pointers, Dcache write FSM and occupancy/ROB status.
// STORE_BUFFER_STB_EN enables byte stores (byte_in port, byte-lane masking).
module store_buffer
  import lc3b_types::*;
#(
  parameter int data_width   = 16,
  parameter int entries_addr = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE,
  input  logic                  flush,
  input  logic [data_width-1:0] base_V,
  input  logic                  base_valid,
  input  lc3b_rob_addr          base_Q,
  input  logic [data_width-1:0] src_V,
  input  logic                  src_valid,
  input  lc3b_rob_addr          src_Q,
  input  logic [data_width-1:0] offset_in,
  input  lc3b_rob_addr          dest_in,
  input  cdb_t                  CDB_in,
  input  logic                  commit,
  input  lc3b_rob_addr          commit_tag,
`ifdef STORE_BUFFER_STB_EN
  input  logic                  byte_in,
`endif
  output logic                  empty,
  output logic                  full,
  output logic                  rob_ready,
  output lc3b_rob_addr          rob_tag,
  store_buffer_if.master        dmem
);
  localparam int DEPTH = 1 << entries_addr;

  sb_state_t               state;
  logic [entries_addr-1:0] head, tail;
  logic [entries_addr:0]   count, keep_cnt;
  logic                    accept, pop;
  logic                    head_valid, head_ready, head_committed, head_commit_hit;
  logic [data_width-1:0]   head_base, head_src, head_offset, eff_addr;
  lc3b_rob_addr            head_dest;
  logic [data_width-1:0]   addr_q, wdata_q;
  logic [1:0]              wmask_q;
  logic                    write_q;
`ifdef STORE_BUFFER_STB_EN
  logic                    head_byte;
`endif

  assign empty    = (count == '0);
  assign full     = (count == DEPTH[entries_addr:0]);
  assign accept   = WE && !flush && !full;
  assign pop      = (state == WRITE) && dmem.dmem_resp;
  assign eff_addr = head_base + head_offset;

  store_buffer_data #(.data_width(data_width), .entries_addr(entries_addr)) u_data (
    .clk(clk), .rst(rst), .alloc(accept), .tail(tail), .head(head), .pop(pop),
    .flush(flush), .commit(commit), .commit_tag(commit_tag), .cdb(CDB_in),
    .base_V(base_V), .base_valid(base_valid), .base_Q(base_Q),
    .src_V(src_V), .src_valid(src_valid), .src_Q(src_Q),
    .offset_in(offset_in), .dest_in(dest_in),
`ifdef STORE_BUFFER_STB_EN
    .byte_in(byte_in), .head_byte(head_byte),
`endif
    .head_valid(head_valid), .head_ready(head_ready), .head_committed(head_committed),
    .head_commit_hit(head_commit_hit), .head_base(head_base), .head_src(head_src),
    .head_offset(head_offset), .head_dest(head_dest), .keep_cnt(keep_cnt)
  );

  // Commit is bypassed into the IDLE check so the write starts the cycle after commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state)
        IDLE: if (head_valid && (head_committed || head_commit_hit)) begin
          state   <= WRITE;
          write_q <= 1'b1;
          addr_q  <= eff_addr;
`ifdef STORE_BUFFER_STB_EN
          if (head_byte) begin
            wdata_q <= {head_src[7:0], head_src[7:0]};
            wmask_q <= eff_addr[0] ? 2'b10 : 2'b01;
          end else begin
            wdata_q <= head_src;
            wmask_q <= 2'b11;
          end
`else
          wdata_q <= head_src;
          wmask_q <= 2'b11;
`endif
        end
        WRITE: if (dmem.dmem_resp) begin
          state   <= IDLE;
          write_q <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      endcase
      head <= head + entries_addr'(pop);
      // Committed entries are a prefix from head, so the survivors end at head + keep_cnt.
      if (flush) begin
        tail  <= head + keep_cnt[entries_addr-1:0];
        count <= keep_cnt - (entries_addr+1)'(pop);
      end else begin
        tail  <= tail + entries_addr'(accept);
        count <= count + (entries_addr+1)'(accept) - (entries_addr+1)'(pop);
      end
    end
  end

  assign dmem.dmem_write = write_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wmask = wmask_q;
  assign rob_ready       = head_valid & head_ready & ~head_committed;
  assign rob_tag         = head_valid ? head_dest : '0;
endmodule
